// File: rtl/hazard_sequencer_if.sv
// Hazard controller bundle: pipeline condition inputs and
// per-stage stall/flush/redirect outputs plus perf counters.
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rdE;
    logic             memReadE;
    logic             pcSrcE;
    logic             memReqM;
    logic             memReadyM;
    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             stallE;
    logic             flushE;
    logic             stallM;
    logic             flushW;
    logic             redirectF;
    logic             memErr;
    logic [CNT_W-1:0] stallCount;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output rs1D, rs2D, rdE, memReadE, pcSrcE, memReqM, memReadyM,
        input  stallF, stallD, flushD, stallE, flushE, stallM, flushW,
        input  redirectF, memErr, stallCount, flushCount
    );

    modport slave (
        input  rs1D, rs2D, rdE, memReadE, pcSrcE, memReqM, memReadyM,
        output stallF, stallD, flushD, stallE, flushE, stallM, flushW,
        output redirectF, memErr, stallCount, flushCount
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Central hazard controller for the 5-stage pipe: load-use,
// control-transfer and data-memory-wait stall/flush generation.
module hazard_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0
) (
    input logic               clk,
    input logic               rst,
    hazard_sequencer_if.slave hz
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    state_t        state_n;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_n;
    logic          lu;
    logic          ms;
    logic          abort;

    always_comb begin
        lu = hz.memReadE && (hz.rdE != 5'd0) &&
             ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
        ms = (state == RUN) ? (hz.memReqM && !hz.memReadyM)
                            : !hz.memReadyM;
        // wcnt counts stall cycles already spent before this one
        abort = (TIMEOUT != 0) && ms &&
                (wcnt == WW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        case (state)
            RUN: begin
                if (ms && !abort) begin
                    state_n = MEM_WAIT;
                    if (TIMEOUT != 0) wcnt_n = wcnt + WW'(1);
                end else begin
                    wcnt_n = '0;
                end
            end
            MEM_WAIT: begin
                if (!ms || abort) begin
                    state_n = RUN;
                    wcnt_n  = '0;
                end else if (TIMEOUT != 0) begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            default: begin
                state_n = RUN;
                wcnt_n  = '0;
            end
        endcase
    end

    always_comb begin
        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.flushD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.flushE    = 1'b0;
        hz.stallM    = 1'b0;
        hz.flushW    = 1'b0;
        hz.redirectF = 1'b0;
        hz.memErr    = abort;
        priority case (1'b1)
            ms: begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.stallE = 1'b1;
                hz.stallM = 1'b1;
                hz.flushW = 1'b1;
            end
            hz.pcSrcE: begin
                hz.redirectF = 1'b1;
                hz.flushD    = 1'b1;
                hz.flushE    = 1'b1;
            end
            lu: begin
                hz.stallF = 1'b1;
                hz.stallD = 1'b1;
                hz.flushE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz.stallCount <= '0;
            hz.flushCount <= '0;
        end else begin
            if (hz.stallF && (hz.stallCount != '1))
                hz.stallCount <= hz.stallCount + CNT_W'(1);
            if ((hz.flushD || hz.flushE) && (hz.flushCount != '1))
                hz.flushCount <= hz.flushCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_hazard_sequencer;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

    hazard_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    always #5 clk = ~clk;

    // model: waiting flag, stall streak length, counters
    bit         m_wait;
    int         m_streak;
    int         m_sc;
    int         m_fc;
    bit         e_ms;
    bit         e_err;
    logic [8:0] exp_o;

    // {stallF,stallD,flushD,stallE,flushE,stallM,flushW,redirectF,memErr}
    function automatic logic [8:0] dut_o();
        return {hz.stallF, hz.stallD, hz.flushD, hz.stallE, hz.flushE,
                hz.stallM, hz.flushW, hz.redirectF, hz.memErr};
    endfunction

    task automatic model_reset();
        m_wait = 0; m_streak = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic apply(input int rs1, input int rs2, input int rd,
                         input bit mr, input bit pc,
                         input bit req, input bit rdy);
        bit lu;
        hz.rs1D = 5'(rs1); hz.rs2D = 5'(rs2); hz.rdE = 5'(rd);
        hz.memReadE = mr; hz.pcSrcE = pc;
        hz.memReqM = req; hz.memReadyM = rdy;
        lu    = mr && rd != 0 && (rd == rs1 || rd == rs2);
        e_ms  = m_wait ? !rdy : (req && !rdy);
        e_err = e_ms && m_streak == TIMEOUT - 1;
        if (e_ms)      exp_o = {9'b110101100} | {8'b0, e_err};
        else if (pc)   exp_o = 9'b001010010;
        else if (lu)   exp_o = 9'b110010000;
        else           exp_o = 9'b0;
        #1;
    endtask

    task automatic tick();
        if (exp_o[8] && m_sc < CMAX) m_sc++;
        if ((exp_o[6] || exp_o[4]) && m_fc < CMAX) m_fc++;
        if (e_ms && !e_err) begin
            m_wait = 1; m_streak++;
        end else begin
            m_wait = 0; m_streak = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_o() !== 9'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b want=%b", dut_o(), 9'b0);
        end
        checks++;
        if (hz.stallCount !== '0 || hz.flushCount !== '0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d want=0/0",
                     hz.stallCount, hz.flushCount);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        apply(5, 7, 5, 1, 0, 0, 1);
        checks++;
        if (dut_o() !== 9'b110010000) begin
            failures++;
            $display("FAIL lu_outs got=%b want=%b", dut_o(), 9'b110010000);
        end
        tick();
        apply(5, 7, 0, 0, 0, 0, 1);
        checks++;
        if (dut_o() !== 9'b0 || hz.stallCount !== CNT_W'(1)) begin
            failures++;
            $display("FAIL lu_after got=%b cnt=%0d want=0 cnt=1",
                     dut_o(), hz.stallCount);
        end
        tick();
        apply(0, 3, 0, 1, 0, 0, 1);
        checks++;
        if (dut_o() !== 9'b0) begin
            failures++;
            $display("FAIL lu_x0 got=%b want=%b", dut_o(), 9'b0);
        end
        tick();
        apply(4, 9, 9, 1, 0, 0, 1);
        checks++;
        if (dut_o() !== 9'b110010000) begin
            failures++;
            $display("FAIL lu_rs2 got=%b want=%b", dut_o(), 9'b110010000);
        end
        tick();
    endtask

    task automatic test_branch_over_lu();
        int fc0;
        do_reset();
        fc0 = int'(hz.flushCount);
        apply(6, 1, 6, 1, 1, 0, 1);
        checks++;
        if (dut_o() !== 9'b001010010) begin
            failures++;
            $display("FAIL br_outs got=%b want=%b", dut_o(), 9'b001010010);
        end
        tick();
        apply(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (int'(hz.flushCount) !== fc0 + 1 || hz.stallCount !== '0) begin
            failures++;
            $display("FAIL br_cnt got=%0d/%0d want=%0d/0",
                     hz.flushCount, hz.stallCount, fc0 + 1);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 1, 1, 0);
            checks++;
            if (dut_o() !== 9'b110101100) begin
                failures++;
                $display("FAIL mw_stall%0d got=%b want=%b",
                         i, dut_o(), 9'b110101100);
            end
            tick();
        end
        apply(0, 0, 0, 0, 1, 1, 1);
        checks++;
        if (dut_o() !== 9'b001010010) begin
            failures++;
            $display("FAIL mw_release got=%b want=%b",
                     dut_o(), 9'b001010010);
        end
        tick();
        apply(0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (dut_o() !== 9'b0 || hz.stallCount !== CNT_W'(3)) begin
            failures++;
            $display("FAIL mw_run got=%b cnt=%0d want=0 cnt=3",
                     dut_o(), hz.stallCount);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 0, 0, 1, 0);
            checks++;
            if (hz.memErr !== (i == 3) || hz.stallF !== 1'b1) begin
                failures++;
                $display("FAIL to_cycle%0d got err=%b stallF=%b want err=%b stallF=1",
                         i, hz.memErr, hz.stallF, (i == 3));
            end
            tick();
        end
        // held memory-ready low while the pipe itself has no request
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_o() !== exp_o) begin
            failures++;
            $display("FAIL to_wait got=%b want=%b", dut_o(), exp_o);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            apply(3, 0, 3, 1, 0, 0, 1);
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (hz.stallCount !== CNT_W'(CMAX)) begin
            failures++;
            $display("FAIL sat got=%0d want=%0d", hz.stallCount, CMAX);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        checks++;
        if (dut_o() !== 9'b0 || hz.stallCount !== '0 || hz.flushCount !== '0) begin
            failures++;
            $display("FAIL rst_wait got=%b cnt=%0d/%0d want=0",
                     dut_o(), hz.stallCount, hz.flushCount);
        end
        @(negedge clk);
        rst = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_o() !== 9'b0) begin
            failures++;
            $display("FAIL rst_run got=%b want=0", dut_o());
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 6));
            checks++;
            if (dut_o() !== exp_o ||
                int'(hz.stallCount) !== m_sc ||
                int'(hz.flushCount) !== m_fc) begin
                failures++;
                $display("FAIL rand%0d got=%b %0d/%0d want=%b %0d/%0d",
                         i, dut_o(), hz.stallCount, hz.flushCount,
                         exp_o, m_sc, m_fc);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        exp_o = '0; e_ms = 0; e_err = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_over_lu();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
